// File: rtl/store_align_buffer.sv
// store_align_buffer: aligns execute-stage stores onto the byte lanes of a
// 32-bit data memory, queues up to DEPTH of them and drains them in order
// with a req/ack handshake.
// Optional feature macro: STORE_MISALIGN_TRAP_EN (misaligned sh/sw dropped,
// st_misalign pulsed); undefined -> low address bits truncated.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   st_valid/st_ready           store request handshake
//   st_addr/st_data/st_funct3   byte address, rs2 value, sb/sh/sw select
//   mem_req/mem_ack             write request / one-cycle accept
//   mem_addr/mem_wdata/mem_wstrb word address, lane data, byte enables
//   busy                        queue non-empty or write outstanding
//   st_misalign                 misaligned-store pulse (trap build only)
module store_align_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct3,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              busy,
  output logic              st_misalign
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-3:0] waddr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, next_state;
  entry_t           fifo [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [1:0]       off;
  logic             legal, misalign, push, pop, mem_req_d;
  entry_t           enq;

  assign off = st_addr[1:0];

  // Lane alignment and strobe generation for the incoming store
  always_comb begin
    legal     = 1'b1;
    enq.waddr = st_addr[ADDR_W-1:2];
    enq.wdata = '0;
    enq.wstrb = '0;
    case (st_funct3)
      3'b000: begin
        enq.wdata = {4{st_data[7:0]}};
        enq.wstrb = 4'b0001 << off;
      end
      3'b001: begin
        enq.wdata = {2{st_data[15:0]}};
        enq.wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        enq.wdata = st_data;
        enq.wstrb = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = ((st_funct3 == 3'b001) && off[0]) ||
                    ((st_funct3 == 3'b010) && (off != 2'b00));

  // One-cycle pulse following the accepting edge of a misaligned store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_misalign <= 1'b0;
    else        st_misalign <= st_valid && st_ready && misalign;
  end
`else
  assign misalign    = 1'b0;
  assign st_misalign = 1'b0;
`endif

  // Illegal and trapped stores complete the handshake but are not queued
  assign push = st_valid && st_ready && legal && !misalign;

  // Drain FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Drain FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count != '0) next_state = ISSUE;
      ISSUE:   if (mem_ack && (count == '0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Drain FSM: pop decision and next-cycle request
  always_comb begin
    pop       = 1'b0;
    mem_req_d = (next_state == ISSUE);
    case (state)
      IDLE:    pop = (count != '0);
      ISSUE:   pop = mem_ack && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Queue storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= enq;
  end

  // Pointers, occupancy and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      st_ready  <= 1'b1;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop) begin
        rd_ptr    <= PTR_W'(rd_ptr + 1'b1);
        mem_addr  <= {fifo[rd_ptr].waddr, 2'b00};
        mem_wdata <= fifo[rd_ptr].wdata;
        mem_wstrb <= fifo[rd_ptr].wstrb;
      end
      count    <= count_next;
      // Full-ness is judged on the settled count, so a same-cycle pop never reopens early
      st_ready <= (count_next != CNT_W'(DEPTH));
      mem_req  <= mem_req_d;
      busy     <= (count_next != '0) || (next_state == ISSUE);
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Testbench for store_align_buffer: directed scenarios plus a randomized
// phase, all writes checked against a lane-level reference queue.
module tb_store_align_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        st_misalign;

  int checks = 0;
  int errors = 0;

`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_t;

  wr_t  exp_q[$];
  logic mis_pend = 1'b0;
  logic hold = 1'b0;
  wr_t  prev;

  store_align_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .busy(busy), .st_misalign(st_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a store of 'size' bytes covers lanes [start, start+size); lane i carries data byte i%size
  function automatic logic model_accept(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int size;
    int start;
    wr_t w;
    size = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
    if (size == 0) return 1'b0;
    if (TRAP && ((a % size) != 0)) return 1'b1;
    start   = (int'(a % 4) / size) * size;
    w.addr  = a - (a % 4);
    w.wdata = '0;
    w.wstrb = '0;
    for (int i = 0; i < 4; i++) begin
      w.wdata = w.wdata | (((d >> (8 * (i % size))) & 32'hFF) << (8 * i));
      if (i >= start && i < start + size) w.wstrb = w.wstrb | 4'(1 << i);
    end
    exp_q.push_back(w);
    return 1'b0;
  endfunction

  // Scoreboard: sample mid-cycle, mirror acceptances and check every completed write
  always @(negedge clk) begin
    if (rst_n) begin
      chk("st_misalign", 32'(st_misalign), 32'(mis_pend));
      if (hold) begin
        chk("hold_addr", mem_addr, prev.addr);
        chk("hold_wdata", mem_wdata, prev.wdata);
        chk("hold_wstrb", 32'(mem_wstrb), 32'(prev.wstrb));
      end
      if (mem_req && mem_ack) begin
        chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_wdata", mem_wdata, exp_q[0].wdata);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_q[0].wstrb));
          void'(exp_q.pop_front());
        end
      end
      mis_pend = 1'b0;
      if (st_valid && st_ready) mis_pend = model_accept(st_addr, st_data, st_funct3);
      hold = mem_req && !mem_ack;
      prev.addr  = mem_addr;
      prev.wdata = mem_wdata;
      prev.wstrb = mem_wstrb;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int   n;
    logic rdy;
    n = 0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f;
    do begin
      rdy = st_ready;
      cyc();
      n++;
    end while (!rdy && n < 50);
    chk("store_accept", 32'(rdy), 32'd1);
    st_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    mem_ack = 1'b1;
    while (busy && n < limit) begin
      cyc();
      n++;
    end
    mem_ack = 1'b0;
    cyc();
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0; mem_ack = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_misalign", 32'(st_misalign), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // sb to the top lane, one-cycle issue latency
    do_store(32'h103, 32'hAABBCC5A, 3'b000);
    chk("t1_req_latency0", 32'(mem_req), 32'd0);
    cyc();
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_wstrb", 32'(mem_wstrb), 32'h8);
    chk("t1_wdata", mem_wdata, 32'h5A5A5A5A);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("t1_req_drop", 32'(mem_req), 32'd0);

    // sh upper half, ack delayed 5 cycles
    do_store(32'h202, 32'h1234BEEF, 3'b001);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_held", 32'(mem_req), 32'd1);
      chk("t2_wdata", mem_wdata, 32'hBEEFBEEF);
      chk("t2_wstrb", 32'(mem_wstrb), 32'hC);
      chk("t2_addr", mem_addr, 32'h200);
      cyc();
    end
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("t2_idle", 32'(busy), 32'd0);

    // Fill: 1 in output regs + 4 queued, then back-to-back drain
    for (int i = 0; i < 5; i++) do_store(32'h400 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 3'b010);
    chk("t3_full_ready", 32'(st_ready), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_cont", 32'(mem_req), 32'd1);
      cyc();
    end
    mem_ack = 1'b0;
    chk("t3_req_end", 32'(mem_req), 32'd0);
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_ready_back", 32'(st_ready), 32'd1);

    // Misaligned sw
    do_store(32'h301, 32'h87654321, 3'b010);
    chk("t4_misalign_pulse", 32'(st_misalign), 32'(TRAP));
    cyc();
    chk("t4_misalign_clear", 32'(st_misalign), 32'd0);
    chk("t4_req", 32'(mem_req), 32'(!TRAP));
    if (!TRAP) begin
      chk("t4_addr", mem_addr, 32'h300);
      chk("t4_wstrb", 32'(mem_wstrb), 32'hF);
    end
    drain(20);

    // Reset while issuing with 3 queued
    for (int i = 0; i < 4; i++) do_store(32'h500 + 32'(4 * i), $urandom, 3'b010);
    chk("t5_pre_req", 32'(mem_req), 32'd1);
    #3 rst_n = 1'b0;
    exp_q.delete(); mis_pend = 1'b0; hold = 1'b0;
    #1;
    chk("t5_rst_req", 32'(mem_req), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    mem_ack = 1'b1;
    repeat (8) cyc();
    mem_ack = 1'b0;
    chk("t5_no_write", 32'(mem_req), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);

    // Illegal funct3 then a normal sb
    do_store(32'h600, 32'hFFFFFFFF, 3'b011);
    cyc();
    chk("t6_no_req", 32'(mem_req), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    do_store(32'h601, 32'h000000A5, 3'b000);
    cyc();
    chk("t6_sb_req", 32'(mem_req), 32'd1);
    chk("t6_sb_wstrb", 32'(mem_wstrb), 32'h2);
    drain(20);

    // Randomized traffic with random memory backpressure
    for (int i = 0; i < 400; i++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_addr   = $urandom_range(0, 32'hFFFF);
      st_data   = $urandom;
      st_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      mem_ack   = ($urandom_range(0, 2) != 0);
      cyc();
    end
    st_valid = 1'b0;
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
